// File: rtl/sg13g2_trim_ringosc_model.sv
// Cycle-based model of the 13-stage trimmable ring oscillator: one hiclock cycle is one delay unit.
// Optional half_period readback port is enabled by defining RINGOSC_PERIOD_OUT_EN.
module sg13g2_trim_ringosc_model #(
  parameter int NSTAGE     = 13,
  parameter int BASE_DELAY = 13,
  parameter int CNT_W      = 6
) (
  input  logic                  hiclock,
  input  logic                  reset,
  input  logic [2*NSTAGE-1:0]   trim,
`ifdef RINGOSC_PERIOD_OUT_EN
  output logic [CNT_W-1:0]      half_period,
`endif
  output logic [1:0]            clockp
);

  logic [CNT_W-1:0]    cnt;
  logic [2*NSTAGE-1:0] trim_q;
  logic                load_pend;
  logic [2*NSTAGE-1:0] teff;
  logic [CNT_W-1:0]    pop;
  logic [CNT_W-1:0]    h;
  logic [CNT_W-1:0]    h_half;
  logic                end_half;
  logic                mid_half;

  // Until the first edge after reset, the live trim input sets the first half-period.
  always_comb begin
    teff = load_pend ? trim : trim_q;
    pop  = '0;
    for (int i = 0; i < 2*NSTAGE; i++) begin
      pop = pop + CNT_W'(teff[i]);
    end
    h        = CNT_W'(BASE_DELAY) + pop;
    h_half   = h >> 1;
    end_half = (cnt == h - CNT_W'(1));
    mid_half = (cnt == h_half - CNT_W'(1));
  end

  always_ff @(posedge hiclock or posedge reset) begin
    if (reset) begin
      clockp    <= 2'b00;
      cnt       <= '0;
      trim_q    <= '0;
      load_pend <= 1'b1;
    end else begin
      load_pend <= 1'b0;
      if (load_pend) begin
        trim_q <= trim;
      end
      if (end_half) begin
        cnt       <= '0;
        clockp[0] <= ~clockp[0];
        trim_q    <= trim;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if (mid_half) begin
        clockp[1] <= ~clockp[1];
      end
    end
  end

`ifdef RINGOSC_PERIOD_OUT_EN
  logic [CNT_W-1:0] pop_new;

  // trim_q is reloaded from trim at each half-period boundary, so the next H follows trim.
  always_comb begin
    pop_new = '0;
    for (int i = 0; i < 2*NSTAGE; i++) begin
      pop_new = pop_new + CNT_W'(trim[i]);
    end
  end

  always_ff @(posedge hiclock or posedge reset) begin
    if (reset) begin
      half_period <= CNT_W'(BASE_DELAY);
    end else if (load_pend || end_half) begin
      half_period <= CNT_W'(BASE_DELAY) + pop_new;
    end
  end
`endif

endmodule

// File: tb/tb_sg13g2_trim_ringosc_model.sv
// Directed bench for the trimmable ring oscillator model; expected toggle cycles are hand-computed.
// Covers reset hold, trim=0, all-ones trim, mid-half trim change, async reset mid-run, optional half_period.
module tb_sg13g2_trim_ringosc_model;

  logic        hiclock;
  logic        reset;
  logic [25:0] trim;
  logic [1:0]  clockp;
`ifdef RINGOSC_PERIOD_OUT_EN
  logic [5:0]  half_period;
`endif

  int total;
  int bad;
  logic [1:0] trace [0:99];

  sg13g2_trim_ringosc_model dut (
    .hiclock     (hiclock),
    .reset       (reset),
    .trim        (trim),
`ifdef RINGOSC_PERIOD_OUT_EN
    .half_period (half_period),
`endif
    .clockp      (clockp)
  );

  initial hiclock = 1'b0;
  always #5 hiclock = ~hiclock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Posedge i (counted from 1 after release) leaves clockp in trace[i]; optional trim change after edge chg.
  task automatic capture(input int n, input int chg, input logic [25:0] chg_val);
    for (int i = 1; i <= n; i++) begin
      @(posedge hiclock);
      #1;
      trace[i] = clockp;
      if (i == chg) trim = chg_val;
    end
  endtask

  task automatic restart(input logic [25:0] t);
    @(negedge hiclock);
    reset = 1'b1;
    trim  = t;
    @(negedge hiclock);
    @(negedge hiclock);
    reset = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    trim  = 26'h2A5_5A5A;

    // Held in reset with varied trim: outputs stay low across edges.
    for (int i = 0; i < 4; i++) begin
      @(posedge hiclock);
      #1;
      chk("rst_hold_pos", 32'(clockp), 32'h0);
      trim = 26'($urandom);
      @(negedge hiclock);
      chk("rst_hold_neg", 32'(clockp), 32'h0);
    end
`ifdef RINGOSC_PERIOD_OUT_EN
    chk("hp_reset", 32'(half_period), 32'd13);
`endif

    // trim=0: H=13, mid tap after 6.
    restart(26'h0);
    capture(30, 0, 26'h0);
    chk("t0_p5",  32'(trace[5]),  32'h0);
    chk("t0_p6",  32'(trace[6]),  32'h2);
    chk("t0_p12", 32'(trace[12]), 32'h2);
    chk("t0_p13", 32'(trace[13]), 32'h3);
    chk("t0_p18", 32'(trace[18]), 32'h3);
    chk("t0_p19", 32'(trace[19]), 32'h1);
    chk("t0_p25", 32'(trace[25]), 32'h1);
    chk("t0_p26", 32'(trace[26]), 32'h0);

    // All ones: H=39, mid tap after 19.
    restart('1);
    capture(80, 0, '1);
    chk("t1_p18", 32'(trace[18]), 32'h0);
    chk("t1_p19", 32'(trace[19]), 32'h2);
    chk("t1_p38", 32'(trace[38]), 32'h2);
    chk("t1_p39", 32'(trace[39]), 32'h3);
    chk("t1_p57", 32'(trace[57]), 32'h3);
    chk("t1_p58", 32'(trace[58]), 32'h1);
    chk("t1_p77", 32'(trace[77]), 32'h1);
    chk("t1_p78", 32'(trace[78]), 32'h0);

    // trim 0 -> 3 after edge 5: first half stays 13, second half is 15 (mid at 13+7).
    restart(26'h0);
    capture(30, 5, 26'h3);
    chk("chg_p12", 32'(trace[12]), 32'h2);
    chk("chg_p13", 32'(trace[13]), 32'h3);
    chk("chg_p19", 32'(trace[19]), 32'h3);
    chk("chg_p20", 32'(trace[20]), 32'h1);
    chk("chg_p27", 32'(trace[27]), 32'h1);
    chk("chg_p28", 32'(trace[28]), 32'h0);

    // Async reset mid-run at cycle 20, held 3 cycles, then a clean restart.
    restart(26'h0);
    capture(20, 0, 26'h0);
    chk("mid_p20", 32'(trace[20]), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst", 32'(clockp), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge hiclock);
      #1;
      chk("rst_mid_hold", 32'(clockp), 32'h0);
    end
    @(negedge hiclock);
    reset = 1'b0;
    capture(15, 0, 26'h0);
    chk("rel_p5",  32'(trace[5]),  32'h0);
    chk("rel_p6",  32'(trace[6]),  32'h2);
    chk("rel_p12", 32'(trace[12]), 32'h2);
    chk("rel_p13", 32'(trace[13]), 32'h3);

`ifdef RINGOSC_PERIOD_OUT_EN
    restart(26'h1F);
    @(posedge hiclock);
    #1;
    chk("hp_load", 32'(half_period), 32'd18);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
